dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised data-memory subsystem with a request/done handshake, RV32 byte/half/word access with sign extension, and a programmable access latency. It replaces the fixed zero-latency word-only data memory at the processor top level. Cores can therefore stall on slow memory and execute LB/LH/LW/LBU/LHU/SB/SH/SW natively. It sits between the core's load/store path and the memory array.

## Interface

- DEPTH, 256: memory depth in 32-bit words; power of 2, ≥4
- LATENCY, 2: extra wait cycles per access, 0..15
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  access request; sampled only while busy=0
- we  in  1  1 = store, 0 = load
- addr  in  32  byte address
- funct3  in  3  RV32 load/store funct3 (access size and signedness)
- wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
- busy  out  1  access in flight; req ignored while high
- done  out  1  one-cycle pulse: access complete, rdata and err valid
- rdata  out  32  load result, extended to 32 bits
- err  out  1  access faulted (misaligned or illegal funct3); valid with done

## Operation

- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE: on req=1, latch we, addr, funct3, wdata. Inputs may change freely afterwards. Next state is WAIT if LATENCY>0, else DONE.
- WAIT: a down-counter is loaded with LATENCY-1 on accept. Go to DONE when the counter reaches 0.
- DONE: done=1 for this cycle, busy=0. A new req here is accepted the same as in IDLE: next state is WAIT or DONE. Otherwise next state is IDLE.
- Word index = latched addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH bytes. No range error is raised.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 gives err=1.
- Misalignment: halfword access with addr[0]=1, or word access with addr[1:0]≠0, gives err=1.
- Byte lane selected by addr[1:0]; halfword lane selected by addr[1].
- LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
- Stores write only the addressed byte lanes; other lanes are preserved.
- On err: no memory write, rdata=0.
- Stores: rdata=0, err valid.
- Memory array contents are not reset. Simulation initial contents are 0.

## Timing

- Reset values, asynchronous, while rst=1: state=IDLE, busy=0, done=0, rdata=0, err=0, counter=0.
- Let E0 be the accepting edge.
- Accept: busy=1 from E0 until the edge that enters DONE.
- Completion: the memory write, rdata and err are all registered at edge E0+LATENCY. done=1 during the following cycle.
- Load-to-use latency: LATENCY+1 cycles from the req cycle to the done cycle.
- Throughput: one access per LATENCY+1 cycles when req is held high continuously. With LATENCY=0, one access per cycle.
- Read-after-write: a load accepted in the DONE cycle of a store to the same word returns the new data.
- rdata and err hold their value until the next completion. done is the only qualifier for them.
- req while busy=1: ignored and not queued. The host must re-present it.
- Reset mid-access: the access is aborted, the pending store is not committed, and no done pulse occurs.

## Test plan

- Reset: assert rst mid-cycle with req=1 -> busy=0, done=0, rdata=0, err=0 immediately; deassert -> IDLE, no spurious done.
- LATENCY=2: SW 0xDEADBEEF @0x10 accepted at E0 -> done high in the cycle after E2 with err=0. LW @0x10 -> rdata=0xDEADBEEF, done exactly 3 cycles after the req cycle. busy=1 in between.
- Sub-word: SB 0x80 @0x21 over word 0x11223344 -> word becomes 0x11228044. LB @0x21 -> 0xFFFFFF80. LBU -> 0x00000080. LH @0x22 -> 0x00001122.
- Faults: LW @0x12, SH @0x13, funct3=011 load -> err=1, rdata=0, target word unchanged on re-read.
- Reset mid-access: SW 0x12345678 @0x0, rst pulse during WAIT -> no done. LW @0x0 afterwards returns the prior value.
- LATENCY=0, DEPTH=16: req held high for 4 back-to-back accesses -> 4 consecutive done pulses. SW @0x40 then LW @0x00 returns that value (aliasing).

Source files
------------

// File: rtl/dmem_lsu_if.sv
// Load/store handshake between a core and the data memory.
// The core drives the request fields; the memory returns busy, done and the result.
interface dmem_lsu_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [2:0]  funct3;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, we, addr, funct3, wdata,
                   input  busy, done, rdata, err);
   modport slave  (input  req, we, addr, funct3, wdata,
                   output busy, done, rdata, err);
endinterface

// File: rtl/dmem_lsu.sv
// RV32 data memory with byte/half/word access, sign extension and a programmable
// number of wait cycles per access, driven through a req/done handshake.
module dmem_lsu #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input logic       clk,
   input logic       rst,
   dmem_lsu_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        accept, fire;
   logic        we_q;
   logic [AW+1:0] addr_q;
   logic [2:0]  f3_q;
   logic [31:0] wdata_q;
   logic        op_we, op_err;
   logic [AW+1:0] op_addr;
   logic [2:0]  op_f3;
   logic [31:0] op_wdata;
   logic [AW-1:0] idx;
   logic [31:0] rdata_r;
   logic        err_r;
   logic [31:0] mem [DEPTH];
   logic        unused_addr;

   function automatic logic access_err(input logic w, input logic [2:0] f, input logic [1:0] a);
      case (f)
         3'b000:  access_err = 1'b0;
         3'b001:  access_err = a[0];
         3'b010:  access_err = (a != 2'b00);
         3'b100:  access_err = w;
         3'b101:  access_err = w | a[0];
         default: access_err = 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f,
                                            input logic [1:0] a);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] s;
      b = 8'(word >> {a, 3'b000});
      h = a[1] ? word[31:16] : word[15:0];
      case (f)
         3'b000:  begin s = b; load_ext = s; end
         3'b001:  begin s = h; load_ext = s; end
         3'b100:  load_ext = {24'd0, b};
         3'b101:  load_ext = {16'd0, h};
         default: load_ext = word;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [2:0] f,
                                               input logic [1:0] a, input logic [31:0] d);
      logic [3:0]  be;
      logic [31:0] dd, mask;
      case (f)
         3'b000:  begin be = 4'b0001 << a; dd = {4{d[7:0]}}; end
         3'b001:  begin be = a[1] ? 4'b1100 : 4'b0011; dd = {2{d[15:0]}}; end
         default: begin be = 4'b1111; dd = d; end
      endcase
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      store_merge = (old & ~mask) | (dd & mask);
   endfunction

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         WAIT: if (cnt == 4'd0) state_nxt = DONE;
         default: begin
            state_nxt = IDLE;
            if (bus.req) begin
               accept    = 1'b1;
               state_nxt = (LATENCY > 0) ? WAIT : DONE;
            end
         end
      endcase
   end

   // With zero latency the access completes on the accepting edge, straight from the bus.
   assign fire     = !rst && ((LATENCY == 0) ? accept : (state == WAIT && cnt == 4'd0));
   assign op_we    = (LATENCY == 0) ? bus.we              : we_q;
   assign op_addr  = (LATENCY == 0) ? bus.addr[AW+1:0]    : addr_q;
   assign op_f3    = (LATENCY == 0) ? bus.funct3          : f3_q;
   assign op_wdata = (LATENCY == 0) ? bus.wdata           : wdata_q;
   assign op_err   = access_err(op_we, op_f3, op_addr[1:0]);
   assign idx      = op_addr[AW+1:2];
   assign unused_addr = ^bus.addr[31:AW+2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rdata_r <= 32'd0;
         err_r   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= CNT_INIT;
         else if (state == WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
         if (fire) begin
            err_r   <= op_err;
            rdata_r <= (op_err || op_we) ? 32'd0 : load_ext(mem[idx], op_f3, op_addr[1:0]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.we;
         addr_q  <= bus.addr[AW+1:0];
         f3_q    <= bus.funct3;
         wdata_q <= bus.wdata;
      end
      if (fire && op_we && !op_err)
         mem[idx] <= store_merge(mem[idx], op_f3, op_addr[1:0], op_wdata);
   end

   assign bus.busy  = (state == WAIT);
   assign bus.done  = (state == DONE);
   assign bus.rdata = rdata_r;
   assign bus.err   = err_r;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench: a LATENCY=2/DEPTH=256 instance and a LATENCY=0/DEPTH=16 instance.
module tb_dmem_lsu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   dmem_lsu_if b2 ();
   dmem_lsu_if b0 ();

   dmem_lsu #(.DEPTH(256), .LATENCY(2)) u_lat2 (.clk(clk), .rst(rst), .bus(b2.slave));
   dmem_lsu #(.DEPTH(16),  .LATENCY(0)) u_lat0 (.clk(clk), .rst(rst), .bus(b0.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One access on the LATENCY=2 instance; returns at the done cycle (edge + 1).
   task automatic acc2(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er,
                       output int n, output logic busy_ok);
      b2.req = 1'b1; b2.we = w; b2.funct3 = f; b2.addr = a; b2.wdata = d;
      busy_ok = 1'b1;
      @(posedge clk); #1;
      b2.req = 1'b0; b2.we = ~w; b2.funct3 = 3'b111; b2.addr = 32'hFFFF_FFFF; b2.wdata = 32'h0;
      n = 1;
      while (!b2.done && n < 40) begin
         if (!b2.busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      rd = b2.rdata;
      er = b2.err;
      if (!b2.done) check("timeout", 32'd0, 32'd1);
   endtask

   task automatic ld(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] exp_d, input logic exp_e);
      logic [31:0] rd; logic er; int n; logic bo;
      acc2(1'b0, f, a, 32'h0, rd, er, n, bo);
      check({tag, "_rdata"}, rd, exp_d);
      check({tag, "_err"}, 32'(er), 32'(exp_e));
   endtask

   task automatic st(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic exp_e);
      logic [31:0] rd; logic er; int n; logic bo;
      acc2(1'b1, f, a, d, rd, er, n, bo);
      check({tag, "_rdata"}, rd, 32'd0);
      check({tag, "_err"}, 32'(er), 32'(exp_e));
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic        bo;
      logic        seen;
      int          n;

      b2.req = 1'b0; b2.we = 1'b0; b2.addr = 32'h0; b2.funct3 = 3'b000; b2.wdata = 32'h0;
      b0.req = 1'b0; b0.we = 1'b0; b0.addr = 32'h0; b0.funct3 = 3'b000; b0.wdata = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(b2.busy), 32'd0);
      check("rst_done", 32'(b2.done), 32'd0);
      check("rst_rdata", b2.rdata, 32'd0);
      check("rst_err", 32'(b2.err), 32'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_done", 32'(b2.done), 32'd0);

      // Word store/load and handshake timing
      acc2(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, n, bo);
      check("sw_err", 32'(er), 32'd0);
      check("sw_cycles", 32'(n), 32'd3);
      check("sw_busy", 32'(bo), 32'd1);
      acc2(1'b0, 3'b010, 32'h10, 32'h0, rd, er, n, bo);
      check("lw_rdata", rd, 32'hDEADBEEF);
      check("lw_cycles", 32'(n), 32'd3);
      check("lw_busy", 32'(bo), 32'd1);

      // Sub-word access
      st("sw20", 3'b010, 32'h20, 32'h11223344, 1'b0);
      st("sb21", 3'b000, 32'h21, 32'hABCDEF80, 1'b0);
      ld("lw20", 3'b010, 32'h20, 32'h11228044, 1'b0);
      ld("lb21", 3'b000, 32'h21, 32'hFFFFFF80, 1'b0);
      ld("lbu21", 3'b100, 32'h21, 32'h00000080, 1'b0);
      ld("lh22", 3'b001, 32'h22, 32'h00001122, 1'b0);
      ld("lh20", 3'b001, 32'h20, 32'hFFFF8044, 1'b0);
      ld("lhu20", 3'b101, 32'h20, 32'h00008044, 1'b0);
      st("sh22", 3'b001, 32'h22, 32'h0000BEEF, 1'b0);
      ld("lw20b", 3'b010, 32'h20, 32'hBEEF8044, 1'b0);

      // Faults
      ld("lw12", 3'b010, 32'h12, 32'h0, 1'b1);
      st("sh13", 3'b001, 32'h13, 32'h0000FFFF, 1'b1);
      st("sbu10", 3'b100, 32'h10, 32'h0, 1'b1);
      ld("f3_011", 3'b011, 32'h10, 32'h0, 1'b1);
      ld("lw10_kept", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);

      // Reset in the middle of a store
      st("sw0", 3'b010, 32'h0, 32'hCAFE0001, 1'b0);
      ld("lw0", 3'b010, 32'h0, 32'hCAFE0001, 1'b0);
      b2.req = 1'b1; b2.we = 1'b1; b2.funct3 = 3'b010; b2.addr = 32'h0; b2.wdata = 32'h12345678;
      @(posedge clk); #1;
      check("mid_busy", 32'(b2.busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(b2.busy), 32'd0);
      check("arst_done", 32'(b2.done), 32'd0);
      check("arst_rdata", b2.rdata, 32'd0);
      check("arst_err", 32'(b2.err), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      b2.req = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         seen |= b2.done;
      end
      check("arst_no_done", 32'(seen), 32'd0);
      ld("lw0_prior", 3'b010, 32'h0, 32'hCAFE0001, 1'b0);

      // Zero latency, back-to-back with req held high; 0x40 aliases word 0 at DEPTH=16
      @(posedge clk); #1;
      b0.req = 1'b1; b0.we = 1'b1; b0.funct3 = 3'b010; b0.addr = 32'h40; b0.wdata = 32'hA5A5_0F0F;
      @(posedge clk); #1;
      check("l0_done1", 32'(b0.done), 32'd1);
      check("l0_busy1", 32'(b0.busy), 32'd0);
      b0.we = 1'b0; b0.addr = 32'h00;
      @(posedge clk); #1;
      check("l0_done2", 32'(b0.done), 32'd1);
      check("l0_alias", b0.rdata, 32'hA5A5_0F0F);
      b0.we = 1'b1; b0.addr = 32'h04; b0.wdata = 32'h0BAD_F00D;
      @(posedge clk); #1;
      check("l0_done3", 32'(b0.done), 32'd1);
      check("l0_st_rdata", b0.rdata, 32'd0);
      b0.we = 1'b0; b0.addr = 32'h44;
      @(posedge clk); #1;
      check("l0_done4", 32'(b0.done), 32'd1);
      check("l0_raw", b0.rdata, 32'h0BAD_F00D);
      b0.req = 1'b0;
      @(posedge clk); #1;
      check("l0_idle", 32'(b0.done), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
